// File: rtl/imem_loadable.sv
// imem_loadable: parametrised instruction memory with a registered,
// one-cycle-latency fetch port and a run-time byte-stream loader.
//
// Build option: define IMEM_PARITY_EN to store an even-parity bit with every
// word, check it on fetch, and add the parity_err output. Without the macro
// the memory is 32 bits wide and fetch_fault reports address faults only.
//
// Loader handshake: a byte moves on every rising edge where
// load_byte_valid && load_byte_ready. load_byte_ready is high exactly while
// the FSM is in LOAD and never depends on load_byte_valid. A source may hold
// valid low for any number of cycles; the loader then holds all its state.
module imem_loadable #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned LEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       instruction,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              load_byte_valid,
  input  logic [7:0]        load_byte,
  output logic              load_byte_ready,
  output logic              load_done,
  output logic              busy,
  output logic [LEN_W-1:0]  load_word_cnt
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  // Word index width; a one-word memory still needs a 1-bit index.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = 33;
`else
  localparam int unsigned MEM_W = 32;
`endif

  // Loader FSM. state_q is the single place to observe where the loader is.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;     // clamped word count of this load
  logic [LEN_W-1:0]  cnt_q, cnt_d;     // words written so far
  logic [IDX_W-1:0]  ptr_q, ptr_d;     // next word to write
  logic [1:0]        lane_q, lane_d;   // next byte lane (0 = bits [7:0])
  logic [23:0]       asm_q, asm_d;     // lanes 0..2 of the word in flight

  logic              byte_fire;
  logic              word_wr;
  logic [31:0]       wr_word;
  logic [MEM_W-1:0]  wr_entry;
  logic [LEN_W-1:0]  len_clamped;

  // Storage is deliberately not reset; contents are undefined until loaded.
  logic [MEM_W-1:0]  mem [DEPTH];

  // Fetch-side signals.
  logic              addr_fault;
  logic [IDX_W-1:0]  rd_idx;
  logic [MEM_W-1:0]  rd_entry;
  logic              rd_par_bad;
  logic              fetch_valid_q;
  logic [31:0]       instr_q;
  logic              fault_q;
  logic              perr_q;

  assign byte_fire = load_byte_valid && load_byte_ready;
  assign word_wr   = byte_fire && (lane_q == 2'd3);
  assign wr_word   = {load_byte, asm_q};

`ifdef IMEM_PARITY_EN
  // Even parity: the stored bit makes the 33-bit entry have an even weight.
  assign wr_entry   = {^wr_word, wr_word};
  assign rd_par_bad = ^rd_entry;
`else
  assign wr_entry   = wr_word;
  assign rd_par_bad = 1'b0;
`endif

  // Requests longer than the memory are clamped to the memory depth.
  always_comb begin
    len_clamped = load_len;
    if (64'(load_len) > 64'(DEPTH)) begin
      len_clamped = LEN_W'(DEPTH);
    end
  end

  // Loader next-state logic and the status outputs decoded from the state.
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    lane_d          = lane_q;
    asm_d           = asm_q;
    load_byte_ready = 1'b0;
    load_done       = 1'b0;
    busy            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          len_d  = len_clamped;
          cnt_d  = '0;
          ptr_d  = '0;
          lane_d = 2'd0;
          asm_d  = '0;
          // A zero-length load completes without accepting any byte.
          state_d = (len_clamped == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        load_byte_ready = 1'b1;
        busy            = 1'b1;
        if (byte_fire) begin
          case (lane_q)
            2'd0: asm_d[7:0]   = load_byte;
            2'd1: asm_d[15:8]  = load_byte;
            2'd2: asm_d[23:16] = load_byte;
            default: asm_d     = asm_q;
          endcase
          if (lane_q == 2'd3) begin
            // Lane 3 completes the word; it is written on this same edge.
            lane_d = 2'd0;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == len_q) begin
              state_d = S_DONE;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Loader state registers; a reset mid-load drops the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      lane_q  <= 2'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
    end
  end

  assign load_word_cnt = cnt_q;

  // Memory write port, driven only by completed words from the loader.
  always_ff @(posedge clk) begin
    if (word_wr) begin
      mem[ptr_q] <= wr_entry;
    end
  end

  // Fetch address decode: misaligned or beyond the last word is a fault.
  assign addr_fault = (fetch_addr[1:0] != 2'b00) ||
                      (64'(fetch_addr[ADDR_W-1:2]) >= 64'(DEPTH));
  assign rd_idx     = fetch_addr[IDX_W+1:2];
  assign rd_entry   = mem[rd_idx];

  // Registered fetch result. During LOAD (which includes the cycle of the
  // last-lane write) the pipeline is fed NOPs, so reads never race writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      instr_q       <= NOP_WORD;
      fault_q       <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_req;
      if (fetch_req) begin
        if (busy) begin
          instr_q <= NOP_WORD;
          fault_q <= 1'b0;
          perr_q  <= 1'b0;
        end else if (addr_fault) begin
          instr_q <= NOP_WORD;
          fault_q <= 1'b1;
          perr_q  <= 1'b0;
        end else if (rd_par_bad) begin
          instr_q <= NOP_WORD;
          fault_q <= 1'b1;
          perr_q  <= 1'b1;
        end else begin
          instr_q <= rd_entry[31:0];
          fault_q <= 1'b0;
          perr_q  <= 1'b0;
        end
      end else begin
        // No request: the instruction holds, the flags are only meaningful
        // alongside fetch_valid and return low.
        fault_q <= 1'b0;
        perr_q  <= 1'b0;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign instruction = instr_q;
  assign fetch_fault = fault_q;

`ifdef IMEM_PARITY_EN
  assign parity_err = perr_q;
`else
  // Without parity storage the error register is constant low and unused.
  logic unused_perr;
  assign unused_perr = perr_q ^ rd_par_bad;
`endif

endmodule
